seg_display_decoder: RTL and testbench
======================================

Name: seg_display_decoder

Overview:
- Receive-side counterpart of the hex-to-seven-segment display driver.
- Samples a time-multiplexed two-digit seven-segment bus (segment byte plus one-hot digit select) and decodes each digit pattern back to a hex nibble.
- Requires a stable pattern before accepting it, pairs high and low digits into a byte, and flags illegal patterns.
- Used as a display loop-back checker and panel-snooping front end.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required to accept a digit (legal range 2..7)
- CNT_W, 3, width of the stability counter; must hold STABLE_CYCLES

Ports:
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- SegData  in  8  segment byte: bit7 = dp, bits6..0 = g,f,e,d,c,b,a, active-high
- DigSel  in  2  digit select: 01 = Dig1 (high nibble), 10 = Dig2 (low nibble), 00/11 = blank, ignored
- Value  out  8  last completed byte {hi,lo}
- ValueValid  out  1  one-cycle pulse when Value is updated
- DecodeErr  out  1  one-cycle pulse on an accepted-but-illegal pattern
- HaveValue  out  1  level; 1 once any byte has been completed since reset

Behaviour:
- Reset is one clock, asynchronous and active-low. While Reset_n=0: Value=8'h00, ValueValid=0, DecodeErr=0, HaveValue=0, state=WAIT_HI, counter=0, sample register cleared to DigSel=00.
- Reset asserted mid-operation discards any partial pair and any stability count immediately.
- Input stage: {DigSel,SegData} is registered every edge (sample S). An equality compare against the previous S drives the counter.
- Counter rules:
  - S differs from previous S, or DigSel is 00/11: counter = 1 (0 for blank).
  - S equals previous S and DigSel is valid: counter increments, saturating at STABLE_CYCLES.
- Acceptance: a digit is accepted only on the edge where the counter goes STABLE_CYCLES-1 to STABLE_CYCLES. Holding the pattern longer never re-accepts it; the pattern must change or blank first.
- Decode table for bits6..0 (gfedcba), identical to the encoder:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Illegal pattern: dp=1, or bits6..0 not in the table. On acceptance this pulses DecodeErr for one cycle, discards the digit and forces state to WAIT_HI. Value is unchanged.
- State machine:
  - WAIT_HI: accepted Dig1 stores the hi nibble and moves to WAIT_LO. Accepted Dig2 is ignored (stays in WAIT_HI, no error).
  - WAIT_LO: accepted Dig2 writes Value={hi,lo}, pulses ValueValid, sets HaveValue, and returns to WAIT_HI. Accepted Dig1 overwrites hi and stays in WAIT_LO.
- ValueValid pulses on every completed pair, including a repeat of the same byte.
- Latency: Value, ValueValid and DecodeErr are registered. They change on the edge following the acceptance edge, i.e. STABLE_CYCLES+1 edges after the low pattern first appears on the inputs (input register included).
- Simultaneous events: acceptance and pattern change on the same edge cannot occur, because acceptance requires equality. ValueValid and DecodeErr are mutually exclusive.

Test Plan:
- Normal pair: Dig1=01111111 for 4 cycles, then Dig2=00111001 for 4 cycles -> Value=8'h8C, one ValueValid pulse, HaveValue=1, DecodeErr never asserted.
- Glitch rejection: Dig1=01111111 for 3 cycles then Dig1=00000110 for 4 cycles, then Dig2=0111111 for 4 cycles -> Value=8'h10; 8 is never accepted.
- Illegal patterns: Dig1=00000001 for 4 cycles -> single DecodeErr pulse, state WAIT_HI. Dig1=10111111 (dp set) -> DecodeErr. Value keeps its prior contents in both cases.
- Ordering and hold: Dig2 first is ignored. Then Dig1=1110111 (A) held 20 cycles and Dig2=1111001 (E) held 20 cycles -> exactly one ValueValid, Value=8'hAE.
- Reset mid-operation: hi accepted (Dig1=F), Reset_n pulsed low for 1 cycle, then Dig2=0 accepted -> no ValueValid, Value=8'h00, HaveValue=0.
- Repeat byte: 0x8C sequence sent twice with a blank between -> two ValueValid pulses, Value=8'h8C.

Source files
------------

// File: rtl/seg_display_decoder_if.sv
// Seven-segment bus as seen by a snooping receiver: the segment byte and digit
// select coming in, and the decoded byte plus status going out.
interface seg_display_decoder_if;
  logic [7:0] seg_data;
  logic [1:0] dig_sel;
  logic [7:0] value;
  logic       value_valid;
  logic       decode_err;
  logic       have_value;

  modport master (
    output seg_data, dig_sel,
    input  value, value_valid, decode_err, have_value
  );

  modport slave (
    input  seg_data, dig_sel,
    output value, value_valid, decode_err, have_value
  );
endinterface

// File: rtl/seg_display_decoder.sv
// Decodes a time-multiplexed two-digit seven-segment bus back into a byte.
// A digit must be stable for STABLE_CYCLES samples before it is taken once.
module seg_display_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  seg_display_decoder_if.slave  bus
);

  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_PRE = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [0:0] WAIT_HI = 1'b0;
  localparam logic [0:0] WAIT_LO = 1'b1;

  // Sample stage: {dig_sel, seg_data}
  logic [9:0]       sample_in;
  logic [9:0]       sample_reg;
  logic [9:0]       diff_bits;
  logic             same_sample;
  logic             in_valid;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             accept_reg, accept_next;

  assign sample_in = {bus.dig_sel, bus.seg_data};

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_diff
      assign diff_bits[gi] = sample_in[gi] ^ sample_reg[gi];
    end
  endgenerate

  assign same_sample = ~|diff_bits;
  assign in_valid    = ^bus.dig_sel;

  always_comb begin
    count_next  = count_reg;
    accept_next = 1'b0;
    if (!in_valid) begin
      count_next = '0;
    end else if (!same_sample) begin
      count_next = CNT_W'(1);
    end else if (count_reg != STABLE_MAX) begin
      count_next  = count_reg + CNT_W'(1);
      accept_next = (count_reg == STABLE_PRE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_reg <= '0;
      count_reg  <= '0;
      accept_reg <= 1'b0;
    end else begin
      sample_reg <= sample_in;
      count_reg  <= count_next;
      accept_reg <= accept_next;
    end
  end

  // Pattern decode of the held sample; same table as the encoder side
  logic       pat_legal;
  logic [3:0] nibble;
  logic       digit_legal;
  logic       is_hi;

  always_comb begin
    pat_legal = 1'b1;
    nibble    = 4'h0;
    case (sample_reg[6:0])
      7'b0111111: nibble = 4'h0;
      7'b0000110: nibble = 4'h1;
      7'b1011011: nibble = 4'h2;
      7'b1001111: nibble = 4'h3;
      7'b1100110: nibble = 4'h4;
      7'b1101101: nibble = 4'h5;
      7'b1111101: nibble = 4'h6;
      7'b0000111: nibble = 4'h7;
      7'b1111111: nibble = 4'h8;
      7'b1101111: nibble = 4'h9;
      7'b1110111: nibble = 4'hA;
      7'b1111100: nibble = 4'hB;
      7'b0111001: nibble = 4'hC;
      7'b1011110: nibble = 4'hD;
      7'b1111001: nibble = 4'hE;
      7'b1110001: nibble = 4'hF;
      default:    pat_legal = 1'b0;
    endcase
  end

  assign digit_legal = pat_legal & ~sample_reg[7];
  assign is_hi       = sample_reg[8];

  // Pairing state machine; acts one edge after acceptance on the held sample
  logic [0:0] state_reg, state_next;
  logic [3:0] hi_reg, hi_next;
  logic [7:0] value_reg, value_next;
  logic       value_valid_reg, value_valid_next;
  logic       decode_err_reg, decode_err_next;
  logic       have_value_reg, have_value_next;

  always_comb begin
    state_next       = state_reg;
    hi_next          = hi_reg;
    value_next       = value_reg;
    value_valid_next = 1'b0;
    decode_err_next  = 1'b0;
    have_value_next  = have_value_reg;
    if (accept_reg) begin
      if (!digit_legal) begin
        decode_err_next = 1'b1;
        state_next      = WAIT_HI;
      end else if (is_hi) begin
        hi_next    = nibble;
        state_next = WAIT_LO;
      end else if (state_reg == WAIT_LO) begin
        value_next       = {hi_reg, nibble};
        value_valid_next = 1'b1;
        have_value_next  = 1'b1;
        state_next       = WAIT_HI;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= WAIT_HI;
      hi_reg          <= 4'h0;
      value_reg       <= 8'h00;
      value_valid_reg <= 1'b0;
      decode_err_reg  <= 1'b0;
      have_value_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      hi_reg          <= hi_next;
      value_reg       <= value_next;
      value_valid_reg <= value_valid_next;
      decode_err_reg  <= decode_err_next;
      have_value_reg  <= have_value_next;
    end
  end

  assign bus.value       = value_reg;
  assign bus.value_valid = value_valid_reg;
  assign bus.decode_err  = decode_err_reg;
  assign bus.have_value  = have_value_reg;

endmodule

// File: tb/tb_seg_display_decoder.sv
// Directed bench for seg_display_decoder: hand-computed vectors checked with
// immediate assertions, pulses tallied on the falling edge.
module tb_seg_display_decoder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_asserts = 0;
  int   n_fails = 0;
  int   vv_cnt = 0;
  int   de_cnt = 0;
  int   vv0;
  int   de0;

  seg_display_decoder_if bus ();

  seg_display_decoder #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.value_valid === 1'b1) vv_cnt++;
    if (bus.decode_err === 1'b1) de_cnt++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [1:0] sel, input logic [7:0] seg, input int n);
    for (int i = 0; i < n; i++) begin
      bus.dig_sel  = sel;
      bus.seg_data = seg;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    hold(2'b00, 8'h00, n);
  endtask

  task automatic snap();
    vv0 = vv_cnt;
    de0 = de_cnt;
  endtask

  initial begin
    bus.dig_sel  = 2'b00;
    bus.seg_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_value", int'(bus.value), 'h00);
    check("reset_valid", int'(bus.value_valid), 0);
    check("reset_err",   int'(bus.decode_err), 0);
    check("reset_have",  int'(bus.have_value), 0);
    reset_n = 1'b1;

    // Normal pair 8,C with exact latency
    snap();
    hold(2'b01, 8'h7F, 4);
    hold(2'b10, 8'h39, 3);
    check("pair_early_valid", int'(bus.value_valid), 0);
    hold(2'b10, 8'h39, 1);
    check("pair_accept_edge_valid", int'(bus.value_valid), 0);
    idle(1);
    check("pair_valid_pulse", int'(bus.value_valid), 1);
    check("pair_value", int'(bus.value), 'h8C);
    check("pair_have", int'(bus.have_value), 1);
    idle(1);
    check("pair_valid_drop", int'(bus.value_valid), 0);
    idle(3);
    check("pair_valid_count", vv_cnt - vv0, 1);
    check("pair_err_count", de_cnt - de0, 0);

    // Glitch rejection
    snap();
    hold(2'b01, 8'h7F, 3);
    hold(2'b01, 8'h06, 4);
    hold(2'b10, 8'h3F, 4);
    idle(3);
    check("glitch_value", int'(bus.value), 'h10);
    check("glitch_valid_count", vv_cnt - vv0, 1);
    check("glitch_err_count", de_cnt - de0, 0);

    // Illegal segment pattern and dp set
    snap();
    hold(2'b01, 8'h01, 4);
    idle(3);
    check("illegal_err_count", de_cnt - de0, 1);
    check("illegal_value", int'(bus.value), 'h10);
    hold(2'b01, 8'hBF, 4);
    idle(3);
    check("dp_err_count", de_cnt - de0, 2);
    check("dp_value", int'(bus.value), 'h10);
    check("illegal_valid_count", vv_cnt - vv0, 0);

    // Error after hi forces WAIT_HI, so the following lo is dropped
    snap();
    hold(2'b01, 8'h06, 4);
    hold(2'b01, 8'h01, 4);
    hold(2'b10, 8'h3F, 4);
    idle(3);
    check("err_resync_err_count", de_cnt - de0, 1);
    check("err_resync_valid_count", vv_cnt - vv0, 0);
    check("err_resync_value", int'(bus.value), 'h10);

    // Lo first is ignored; long holds accept once
    snap();
    hold(2'b10, 8'h06, 4);
    idle(2);
    hold(2'b01, 8'h77, 20);
    hold(2'b10, 8'h79, 20);
    idle(3);
    check("hold_valid_count", vv_cnt - vv0, 1);
    check("hold_value", int'(bus.value), 'hAE);
    check("hold_err_count", de_cnt - de0, 0);

    // Same byte twice gives two pulses
    snap();
    hold(2'b01, 8'h7F, 4);
    hold(2'b10, 8'h39, 4);
    idle(2);
    hold(2'b01, 8'h7F, 4);
    hold(2'b10, 8'h39, 4);
    idle(3);
    check("repeat_valid_count", vv_cnt - vv0, 2);
    check("repeat_value", int'(bus.value), 'h8C);

    // Reset after hi accepted discards the partial pair
    hold(2'b01, 8'h71, 4);
    idle(1);
    reset_n = 1'b0;
    #1;
    check("async_reset_value", int'(bus.value), 'h00);
    check("async_reset_have", int'(bus.have_value), 0);
    @(negedge clk);
    reset_n = 1'b1;
    snap();
    hold(2'b10, 8'h3F, 4);
    idle(3);
    check("post_reset_valid_count", vv_cnt - vv0, 0);
    check("post_reset_value", int'(bus.value), 'h00);
    check("post_reset_have", int'(bus.have_value), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
